// File: rtl/led_blink_pkg.sv
// Shared constants for the LED blink array: mode codes, config select codes
// and the power-on blink timing.
package led_blink_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    localparam logic CFG_PERIOD = 1'b0;
    localparam logic CFG_ON     = 1'b1;

    localparam int unsigned DEF_PERIOD_CLKS = 100_000_000;
    localparam int unsigned DEF_ON_CLKS     = 50_000_000;

    // Channel address width; a single channel still gets a 1-bit address.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: blink counter, shadow/active timing registers,
// mode-entry detect and the registered LED drive.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_CLKS,
    parameter int unsigned DEF_ON     = DEF_ON_CLKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sync_restart,
    input  logic             toggle_hit,
    input  logic             cfg_we_period,
    input  logic             cfg_we_on,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             led
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_ON     = CNT_W'(DEF_ON);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] shadow_period_q, shadow_on_q;
    logic [CNT_W-1:0] act_period_q, act_period_n;
    logic [CNT_W-1:0] act_on_q, act_on_n;
    logic [1:0]       prev_mode_q;
    logic             led_n;

    logic             start;
    logic [CNT_W-1:0] period_use, on_use, period_eff, cnt_use;
    logic             wrap;

    // Entering blink or a restart begins a fresh period this very cycle, using
    // the shadow timing, so the first blink cycle is already count 0.
    always_comb begin
        start      = (prev_mode_q != MODE_BLINK) || sync_restart;
        period_use = start ? shadow_period_q : act_period_q;
        on_use     = start ? shadow_on_q : act_on_q;
        period_eff = (period_use == '0) ? ONE : period_use;
        cnt_use    = start ? '0 : cnt_q;
        wrap       = (cnt_use == period_eff - ONE);
    end

    always_comb begin
        cnt_n        = '0;
        led_n        = led;
        act_period_n = shadow_period_q;
        act_on_n     = shadow_on_q;
        case (mode)
            MODE_OFF: led_n = 1'b0;
            MODE_ON:  led_n = 1'b1;
            MODE_BLINK: begin
                led_n = (cnt_use < on_use);
                cnt_n = wrap ? '0 : cnt_use + ONE;
                if (!(wrap || start)) begin
                    act_period_n = act_period_q;
                    act_on_n     = act_on_q;
                end
            end
            default: begin
                if (toggle_hit) begin
                    led_n = ~led;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            led             <= 1'b0;
            prev_mode_q     <= MODE_OFF;
            shadow_period_q <= RST_PERIOD;
            shadow_on_q     <= RST_ON;
            act_period_q    <= RST_PERIOD;
            act_on_q        <= RST_ON;
        end else begin
            cnt_q        <= cnt_n;
            led          <= led_n;
            prev_mode_q  <= mode;
            act_period_q <= act_period_n;
            act_on_q     <= act_on_n;
            if (cfg_we_period) begin
                shadow_period_q <= cfg_data;
            end
            if (cfg_we_on) begin
                shadow_on_q <= cfg_data;
            end
        end
    end

endmodule

// File: rtl/led_blink_array_ctrl.sv
// LED array controller: decodes the toggle and config strobes to the addressed
// channel and instantiates one led_blink_chan per LED.
module led_blink_array_ctrl
    import led_blink_pkg::*;
#(
    parameter int          NUM_LEDS   = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_CLKS,
    parameter int unsigned DEF_ON     = DEF_ON_CLKS,
    localparam int         CH_W       = ch_width(NUM_LEDS)
) (
    input  logic                  clock_sink_clk,
    input  logic                  reset_sink_reset,
    input  logic [2*NUM_LEDS-1:0] mode,
    input  logic                  csr_write,
    input  logic [CH_W-1:0]       csr_chan,
    input  logic                  cfg_write,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic                  cfg_sel,
    input  logic [CNT_W-1:0]      cfg_data,
    input  logic                  sync_restart,
    output logic [NUM_LEDS-1:0]   led_out
);

    // Addresses at or above NUM_LEDS match no channel and are dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        logic toggle_hit, cfg_hit;

        assign toggle_hit = csr_write && (csr_chan == CH_W'(i));
        assign cfg_hit    = cfg_write && (cfg_chan == CH_W'(i));

        led_blink_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_ON     (DEF_ON)
        ) u_chan (
            .clk           (clock_sink_clk),
            .rst           (reset_sink_reset),
            .mode          (mode[2*i +: 2]),
            .sync_restart  (sync_restart),
            .toggle_hit    (toggle_hit),
            .cfg_we_period (cfg_hit && (cfg_sel == CFG_PERIOD)),
            .cfg_we_on     (cfg_hit && (cfg_sel == CFG_ON)),
            .cfg_data      (cfg_data),
            .led           (led_out[i])
        );
    end

endmodule
